// File: rtl/mem_rd_responder.sv
// 256 x 16 read responder: self-initialising RAM with a fixed-latency read pipeline,
// a side write port for preloading, and sticky misuse flags for accesses during INIT.
module mem_rd_responder #(
  parameter int LATENCY      = 2,
  parameter int INIT_PATTERN = 1
) (
  input  logic        i_clk,
  input  logic        i_reset_p,
  input  logic [7:0]  i_ram_rd_addr,
  input  logic        i_ram_rd_read,
  output logic [15:0] o_ram_rd_data,
  output logic        o_ram_rd_valid,
  input  logic        i_wr_en,
  input  logic [7:0]  i_wr_addr,
  input  logic [15:0] i_wr_data,
  output logic        o_init_done,
  output logic        o_rd_err,
  output logic        o_wr_err,
  output logic [15:0] o_rd_cnt
);

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [7:0]  r_init_addr;
  logic [15:0] w_init_word;
  logic        w_in_init;
  logic        w_mem_we;
  logic [7:0]  w_mem_waddr;
  logic [15:0] w_mem_wdata;

  logic [15:0] r_mem [0:255];
  logic [15:0] r_mem_q;
  logic        r_req_v;
  logic        r_req_dead;
  logic [15:0] w_req_data;

  logic [LATENCY-1:0]       r_pipe_v;
  logic [LATENCY-1:0][15:0] r_pipe_d;
  logic [LATENCY-1:0]       w_stage_v;
  logic [LATENCY-1:0][15:0] w_stage_d;

  logic        r_rd_err;
  logic        r_wr_err;
  logic [15:0] r_rd_cnt;

  generate
    if (INIT_PATTERN == 0) begin : g_init_zero
      assign w_init_word = 16'h0000;
    end else begin : g_init_addr
      assign w_init_word = {~r_init_addr, r_init_addr};
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (i_reset_p) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_INIT:  if (r_init_addr == 8'hFF) w_state_next = ST_READY;
      ST_READY: w_state_next = ST_READY;
      default:  w_state_next = ST_INIT;
    endcase
  end

  // The single RAM write port is shared between the init sweep and the side port.
  always_comb begin
    w_in_init   = 1'b0;
    w_mem_we    = 1'b0;
    w_mem_waddr = i_wr_addr;
    w_mem_wdata = i_wr_data;
    o_init_done = 1'b0;
    case (r_state)
      ST_INIT: begin
        w_in_init   = 1'b1;
        w_mem_we    = ~i_reset_p;
        w_mem_waddr = r_init_addr;
        w_mem_wdata = w_init_word;
      end
      ST_READY: begin
        o_init_done = 1'b1;
        w_mem_we    = i_wr_en & ~i_reset_p;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset_p) begin
      r_init_addr <= 8'h00;
    end else if (w_in_init) begin
      r_init_addr <= r_init_addr + 8'd1;
    end
  end

  // Registered read of the pre-write contents gives read-before-write on collisions.
  always_ff @(posedge i_clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_waddr] <= w_mem_wdata;
    end
    r_mem_q <= r_mem[i_ram_rd_addr];
  end

  always_ff @(posedge i_clk) begin
    if (i_reset_p) begin
      r_req_v    <= 1'b0;
      r_req_dead <= 1'b0;
    end else begin
      r_req_v    <= i_ram_rd_read;
      r_req_dead <= w_in_init;
    end
  end

  assign w_req_data = r_req_dead ? 16'hDEAD : r_mem_q;

  genvar gi;
  generate
    for (gi = 0; gi < LATENCY; gi++) begin : g_stage_in
      if (gi == 0) begin : g_first
        assign w_stage_v[gi] = r_req_v;
        assign w_stage_d[gi] = w_req_data;
      end else begin : g_next
        assign w_stage_v[gi] = r_pipe_v[gi-1];
        assign w_stage_d[gi] = r_pipe_d[gi-1];
      end
    end
  endgenerate

  // Each stage only loads data alongside a valid bit, so the output holds between responses.
  always_ff @(posedge i_clk) begin
    if (i_reset_p) begin
      r_pipe_v <= '0;
      r_pipe_d <= '0;
    end else begin
      for (int i = 0; i < LATENCY; i++) begin
        r_pipe_v[i] <= w_stage_v[i];
        if (w_stage_v[i]) begin
          r_pipe_d[i] <= w_stage_d[i];
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset_p) begin
      r_rd_err <= 1'b0;
      r_wr_err <= 1'b0;
      r_rd_cnt <= 16'h0000;
    end else begin
      if (i_ram_rd_read && w_in_init) r_rd_err <= 1'b1;
      if (i_wr_en && w_in_init) r_wr_err <= 1'b1;
      if (i_ram_rd_read && !w_in_init) r_rd_cnt <= r_rd_cnt + 16'd1;
    end
  end

  assign o_ram_rd_valid = r_pipe_v[LATENCY-1];
  assign o_ram_rd_data  = r_pipe_d[LATENCY-1];
  assign o_rd_err       = r_rd_err;
  assign o_wr_err       = r_wr_err;
  assign o_rd_cnt       = r_rd_cnt;

endmodule
